// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt priority resolver: channel count,
// index width, FSM state encoding, spurious index and a priority-rank helper.
package pic_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned IDX_W   = 3;

  // Index reported when no candidate exists, and the channel that is lowest
  // priority out of reset (IR0 highest).
  localparam logic [IDX_W-1:0] SPURIOUS_IDX    = IDX_W'(7);
  localparam logic [IDX_W-1:0] RESET_LOWEST_IDX = IDX_W'(7);

  typedef enum logic {
    IDLE,
    WAIT_ACK2
  } pic_state_e;

  // Rank of a channel under the current rotation: 0 is highest priority,
  // NUM_IRQ-1 is the lowest-priority channel itself.
  function automatic logic [IDX_W-1:0] prio_rank(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] lowest);
    prio_rank = idx - lowest - IDX_W'(1);
  endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Rotating priority encoder: finds the highest-priority set bit of cand_i when
// priority runs from (lowest_prio_i+1) mod 8 upward, wrapping to lowest_prio_i.
//   cand_i        request vector to search
//   lowest_prio_i channel currently at lowest priority
//   valid_o       at least one bit of cand_i is set
//   idx_o         winning channel, SPURIOUS_IDX when valid_o is 0
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] cand_i,
  input  logic [IDX_W-1:0]   lowest_prio_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] pos;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = SPURIOUS_IDX;
    pos     = '0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      pos = lowest_prio_i + IDX_W'(k + 1);
      if (cand_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/irq_priority_resolver.sv
// 8-channel interrupt priority resolver with edge/level capture, masking,
// fully nested in-service blocking, rotating priority and a two-pulse INTA
// acknowledge handshake.
//   clk, rst             clock, synchronous active-high reset
//   ir_in, ltim          request lines and trigger mode (1 = level)
//   imr, in_service      request mask and in-service vector
//   rotate_en/_set/_idx  rotation control
//   eoi_valid, eoi_idx   end-of-interrupt notification
//   ack1, ack2           first and second INTA pulses
//   int_out              registered interrupt request to the CPU
//   highest_priority_idx selected channel
//   irr, lowest_prio     request register and current lowest-priority channel
module irq_priority_resolver
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic               ltim,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [NUM_IRQ-1:0] in_service,
  input  logic               rotate_en,
  input  logic               rotate_set,
  input  logic [IDX_W-1:0]   rotate_idx,
  input  logic               eoi_valid,
  input  logic [IDX_W-1:0]   eoi_idx,
  input  logic               ack1,
  input  logic               ack2,
  output logic               int_out,
  output logic [IDX_W-1:0]   highest_priority_idx,
  output logic [NUM_IRQ-1:0] irr,
  output logic [IDX_W-1:0]   lowest_prio
);

  pic_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] ir_q;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               int_q, int_d;
  logic [IDX_W-1:0]   lowest_q, lowest_d;

  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] set_req;
  logic               win_valid, isr_valid;
  logic [IDX_W-1:0]   win_idx, isr_idx;
  logic               req_ok;

  assign cand    = irr_q & ~imr;
  assign set_req = ltim ? ir_in : (ir_in & ~ir_q);

  // Best pending candidate.
  pic_rot_prio_enc u_win_enc (
    .cand_i        (cand),
    .lowest_prio_i (lowest_q),
    .valid_o       (win_valid),
    .idx_o         (win_idx)
  );

  // Highest-priority channel currently in service.
  pic_rot_prio_enc u_isr_enc (
    .cand_i        (in_service),
    .lowest_prio_i (lowest_q),
    .valid_o       (isr_valid),
    .idx_o         (isr_idx)
  );

  // Fully nested: the candidate must strictly outrank every in-service channel.
  assign req_ok = win_valid &&
                  (!isr_valid || (prio_rank(win_idx, lowest_q) < prio_rank(isr_idx, lowest_q)));

  // Next-state, request register and rotation logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    int_d    = 1'b0;
    irr_d    = irr_q;
    lowest_d = lowest_q;

    // New requests are frozen while an acknowledge sequence is open.
    if (state_q == IDLE) begin
      irr_d = irr_q | set_req;
    end
    irr_d = irr_d & ir_in;

    case (state_q)
      IDLE: begin
        int_d = req_ok;
        if (ack1) begin
          state_d = WAIT_ACK2;
          int_d   = 1'b0;
          sel_d   = win_valid ? win_idx : SPURIOUS_IDX;
          // Clearing the acknowledged bit overrides any same-cycle set.
          if (win_valid) begin
            irr_d[win_idx] = 1'b0;
          end
        end
      end
      WAIT_ACK2: begin
        if (ack2) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rotate_set) begin
      lowest_d = rotate_idx;
    end else if (eoi_valid && rotate_en) begin
      lowest_d = eoi_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      irr_q    <= '0;
      sel_q    <= '0;
      int_q    <= 1'b0;
      lowest_q <= RESET_LOWEST_IDX;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_in;
      irr_q    <= irr_d;
      sel_q    <= sel_d;
      int_q    <= int_d;
      lowest_q <= lowest_d;
    end
  end

  assign highest_priority_idx = (state_q == WAIT_ACK2) ? sel_q : win_idx;
  assign int_out              = int_q;
  assign irr                  = irr_q;
  assign lowest_prio          = lowest_q;

endmodule

// File: tb/tb_irq_priority_resolver.sv
// Directed self-checking bench for irq_priority_resolver.
module tb_irq_priority_resolver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ir_in = '0;
  logic       ltim = 1'b0;
  logic [7:0] imr = '0;
  logic [7:0] in_service = '0;
  logic       rotate_en = 1'b0;
  logic       rotate_set = 1'b0;
  logic [2:0] rotate_idx = '0;
  logic       eoi_valid = 1'b0;
  logic [2:0] eoi_idx = '0;
  logic       ack1 = 1'b0;
  logic       ack2 = 1'b0;
  logic       int_out;
  logic [2:0] highest_priority_idx;
  logic [7:0] irr;
  logic [2:0] lowest_prio;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_priority_resolver dut (
    .clk                  (clk),
    .rst                  (rst),
    .ir_in                (ir_in),
    .ltim                 (ltim),
    .imr                  (imr),
    .in_service           (in_service),
    .rotate_en            (rotate_en),
    .rotate_set           (rotate_set),
    .rotate_idx           (rotate_idx),
    .eoi_valid            (eoi_valid),
    .eoi_idx              (eoi_idx),
    .ack1                 (ack1),
    .ack2                 (ack2),
    .int_out              (int_out),
    .highest_priority_idx (highest_priority_idx),
    .irr                  (irr),
    .lowest_prio          (lowest_prio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ir_in = '0; ltim = 1'b0; imr = '0; in_service = '0;
    rotate_en = 1'b0; rotate_set = 1'b0; rotate_idx = '0;
    eoi_valid = 1'b0; eoi_idx = '0; ack1 = 1'b0; ack2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ltim = 1'b1; ir_in = 8'hFF;
    tick();
    n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL reset_irr: got %h want 00", irr); end
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", int_out); end
    n_cmp++; if (lowest_prio !== 3'd7) begin n_fail++; $display("FAIL reset_lowest: got %0d want 7", lowest_prio); end
    n_cmp++; if (highest_priority_idx !== 3'd7) begin n_fail++; $display("FAIL reset_idx: got %0d want 7", highest_priority_idx); end
    do_reset();
  endtask

  task automatic test_edge_mode();
    do_reset();
    ltim = 1'b0; ir_in = 8'h24;
    tick();
    n_cmp++; if (irr !== 8'h24) begin n_fail++; $display("FAIL edge_irr: got %h want 24", irr); end
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL edge_int_early: got %b want 0", int_out); end
    n_cmp++; if (highest_priority_idx !== 3'd2) begin n_fail++; $display("FAIL edge_idx: got %0d want 2", highest_priority_idx); end
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL edge_int: got %b want 1", int_out); end
    ir_in = 8'h00;
    tick();
    n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL edge_clear: got %h want 00", irr); end
    tick();
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL edge_int_drop: got %b want 0", int_out); end
  endtask

  task automatic test_nesting();
    do_reset();
    ltim = 1'b1; ir_in = 8'h08; in_service = 8'h04;
    tick(); tick();
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL nest_higher_isr: got %b want 0", int_out); end
    in_service = 8'h08;
    tick();
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL nest_equal_isr: got %b want 0", int_out); end
    in_service = 8'h00;
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL nest_no_isr: got %b want 1", int_out); end
    in_service = 8'h10;
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL nest_lower_isr: got %b want 1", int_out); end
    in_service = 8'h00; imr = 8'h08;
    tick();
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL nest_masked_int: got %b want 0", int_out); end
    n_cmp++; if (highest_priority_idx !== 3'd7) begin n_fail++; $display("FAIL nest_masked_idx: got %0d want 7", highest_priority_idx); end
  endtask

  task automatic test_ack_sequence();
    do_reset();
    ltim = 1'b1; ir_in = 8'h0C;
    tick(); tick();
    n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL ack_int_pre: got %b want 1", int_out); end
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    n_cmp++; if (irr !== 8'h08) begin n_fail++; $display("FAIL ack_irr: got %h want 08", irr); end
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL ack_int_drop: got %b want 0", int_out); end
    n_cmp++; if (highest_priority_idx !== 3'd2) begin n_fail++; $display("FAIL ack_idx: got %0d want 2", highest_priority_idx); end
    ir_in = 8'h0D; ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    tick();
    n_cmp++; if (irr !== 8'h08) begin n_fail++; $display("FAIL wait_irr_frozen: got %h want 08", irr); end
    n_cmp++; if (highest_priority_idx !== 3'd2) begin n_fail++; $display("FAIL wait_idx_held: got %0d want 2", highest_priority_idx); end
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL wait_int: got %b want 0", int_out); end
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    n_cmp++; if (highest_priority_idx !== 3'd3) begin n_fail++; $display("FAIL ack2_idx: got %0d want 3", highest_priority_idx); end
    tick();
    n_cmp++; if (irr !== 8'h0D) begin n_fail++; $display("FAIL post_ack2_irr: got %h want 0d", irr); end
    n_cmp++; if (highest_priority_idx !== 3'd0) begin n_fail++; $display("FAIL post_ack2_idx: got %0d want 0", highest_priority_idx); end
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL post_ack2_int: got %b want 1", int_out); end
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    n_cmp++; if (irr !== 8'h0C) begin n_fail++; $display("FAIL clear_wins_irr: got %h want 0c", irr); end
    n_cmp++; if (highest_priority_idx !== 3'd0) begin n_fail++; $display("FAIL clear_wins_idx: got %0d want 0", highest_priority_idx); end
  endtask

  task automatic test_edge_ack();
    do_reset();
    ltim = 1'b0; ir_in = 8'h04;
    tick(); tick();
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    tick();
    n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL edge_ack_irr: got %h want 00", irr); end
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL edge_ack_int: got %b want 0", int_out); end
  endtask

  task automatic test_rotation();
    do_reset();
    ltim = 1'b1; ir_in = 8'h11;
    tick();
    n_cmp++; if (highest_priority_idx !== 3'd0) begin n_fail++; $display("FAIL rot_default_idx: got %0d want 0", highest_priority_idx); end
    rotate_set = 1'b1; rotate_idx = 3'd3;
    tick();
    rotate_set = 1'b0;
    n_cmp++; if (lowest_prio !== 3'd3) begin n_fail++; $display("FAIL rot_set_lowest: got %0d want 3", lowest_prio); end
    n_cmp++; if (highest_priority_idx !== 3'd4) begin n_fail++; $display("FAIL rot_set_idx: got %0d want 4", highest_priority_idx); end
    rotate_en = 1'b1; eoi_valid = 1'b1; eoi_idx = 3'd4;
    tick();
    eoi_valid = 1'b0;
    n_cmp++; if (lowest_prio !== 3'd4) begin n_fail++; $display("FAIL rot_eoi_lowest: got %0d want 4", lowest_prio); end
    n_cmp++; if (highest_priority_idx !== 3'd0) begin n_fail++; $display("FAIL rot_eoi_idx: got %0d want 0", highest_priority_idx); end
    rotate_en = 1'b0; eoi_valid = 1'b1; eoi_idx = 3'd1;
    tick();
    eoi_valid = 1'b0;
    n_cmp++; if (lowest_prio !== 3'd4) begin n_fail++; $display("FAIL rot_eoi_disabled: got %0d want 4", lowest_prio); end
    rotate_en = 1'b1; eoi_valid = 1'b1; eoi_idx = 3'd6; rotate_set = 1'b1; rotate_idx = 3'd2;
    tick();
    eoi_valid = 1'b0; rotate_set = 1'b0;
    n_cmp++; if (lowest_prio !== 3'd2) begin n_fail++; $display("FAIL rot_set_over_eoi: got %0d want 2", lowest_prio); end
    n_cmp++; if (highest_priority_idx !== 3'd4) begin n_fail++; $display("FAIL rot_set_over_eoi_idx: got %0d want 4", highest_priority_idx); end
  endtask

  task automatic test_spurious_and_abort();
    do_reset();
    ltim = 1'b0; rotate_set = 1'b1; rotate_idx = 3'd5;
    tick();
    rotate_set = 1'b0;
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    n_cmp++; if (highest_priority_idx !== 3'd7) begin n_fail++; $display("FAIL spur_idx: got %0d want 7", highest_priority_idx); end
    n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL spur_irr: got %h want 00", irr); end
    ir_in = 8'h02;
    tick();
    n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL spur_wait_block: got %h want 00", irr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL abort_int: got %b want 0", int_out); end
    n_cmp++; if (lowest_prio !== 3'd7) begin n_fail++; $display("FAIL abort_lowest: got %0d want 7", lowest_prio); end
    n_cmp++; if (highest_priority_idx !== 3'd7) begin n_fail++; $display("FAIL abort_idx: got %0d want 7", highest_priority_idx); end
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    n_cmp++; if (irr !== 8'h02) begin n_fail++; $display("FAIL abort_idle_irr: got %h want 02", irr); end
    n_cmp++; if (highest_priority_idx !== 3'd1) begin n_fail++; $display("FAIL abort_idle_idx: got %0d want 1", highest_priority_idx); end
    tick();
    n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL abort_idle_int: got %b want 1", int_out); end
  endtask

  initial begin
    test_reset();
    test_edge_mode();
    test_nesting();
    test_ack_sequence();
    test_edge_ack();
    test_rotation();
    test_spurious_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
